// File: rtl/lsu_stage_if.sv
// lsu_stage_if: data-memory bus between the load/store stage and memory.
//   Request channel : mem_req_valid / mem_req_ready handshake carrying
//                     mem_addr (word aligned), mem_wen, mem_wdata, mem_wmask.
//   Response channel: mem_resp_valid (no ready) with mem_rdata; for writes the
//                     response is only an acknowledge.
//   master modport  : the load/store stage.
//   slave modport   : the memory.
interface lsu_stage_if #(
    parameter int WIDTH = 32
);
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_wen;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_wmask;
    logic             mem_resp_valid;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_stage.sv
// lsu_stage: multi-cycle load/store stage feeding writeback.
//   clk, rst          : clock; asynchronous active-low reset
//   exu_*             : execute bundle, accepted when exu_valid & exu_ready
//   mem (master)      : data-memory request/response bus
//   lsu_valid         : one-cycle pulse, lsu_data valid
//   lsu_data          : {alu_result, load_data, rd_wen, rd_addr,
//                        rd_input_sel, csr_data}, held until the next DONE
module lsu_stage #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exu_valid,
    output logic               exu_ready,
    input  logic [WIDTH-1:0]   exu_alu_result,
    input  logic [WIDTH-1:0]   exu_wdata,
    input  logic               exu_mem_ren,
    input  logic               exu_mem_wen,
    input  logic [2:0]         exu_mem_op,
    input  logic               exu_rd_wen,
    input  logic [4:0]         exu_rd_addr,
    input  logic [1:0]         exu_rd_input_sel,
    input  logic [WIDTH-1:0]   exu_csr_data,
    lsu_stage_if.master        mem,
    output logic               lsu_valid,
    output logic [3*WIDTH+7:0] lsu_data
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        DONE
    } state_t;

    state_t state, state_nx;

    logic             accept;
    logic             is_mem_in;

    logic [WIDTH-1:0] alu_q;
    logic [WIDTH-1:0] wdata_q;
    logic             load_q;
    logic             store_q;
    logic [2:0]       op_q;
    logic             rd_wen_q;
    logic [4:0]       rd_addr_q;
    logic [1:0]       sel_q;
    logic [WIDTH-1:0] csr_q;

    logic [3:0]       wmask;
    logic [WIDTH-1:0] wdata_lane;
    logic [WIDTH-1:0] rdata_shift;
    logic [15:0]      rdata_half;
    logic [WIDTH-1:0] load_ext;

    assign is_mem_in = exu_mem_ren | exu_mem_wen;
    assign accept    = exu_valid & exu_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx          = state;
        exu_ready         = 1'b0;
        mem.mem_req_valid = 1'b0;
        lsu_valid         = 1'b0;
        unique case (state)
            IDLE: begin
                exu_ready = 1'b1;
                if (exu_valid) begin
                    state_nx = is_mem_in ? REQ : DONE;
                end
            end
            REQ: begin
                mem.mem_req_valid = 1'b1;
                if (mem.mem_req_ready) begin
                    state_nx = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem.mem_resp_valid) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                lsu_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- bundle capture ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_q     <= '0;
            wdata_q   <= '0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            op_q      <= '0;
            rd_wen_q  <= 1'b0;
            rd_addr_q <= '0;
            sel_q     <= '0;
            csr_q     <= '0;
        end else if (accept) begin
            alu_q     <= exu_alu_result;
            wdata_q   <= exu_wdata;
            load_q    <= exu_mem_ren;
            // ren and wen together is a load
            store_q   <= exu_mem_wen & ~exu_mem_ren;
            op_q      <= exu_mem_op;
            rd_wen_q  <= exu_rd_wen;
            rd_addr_q <= exu_rd_addr;
            sel_q     <= exu_rd_input_sel;
            csr_q     <= exu_csr_data;
        end
    end

    // ---------------- store lane steering ----------------
    always_comb begin
        wmask      = 4'b1111;
        wdata_lane = wdata_q;
        unique case (op_q[1:0])
            2'b00: begin
                wmask      = 4'b0001 << alu_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wmask      = alu_q[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            default: begin
                wmask      = 4'b1111;
                wdata_lane = wdata_q;
            end
        endcase
    end

    assign mem.mem_addr  = {alu_q[WIDTH-1:2], 2'b00};
    assign mem.mem_wen   = store_q;
    assign mem.mem_wdata = wdata_lane;
    // Byte enables only mean anything for writes; zero them otherwise so
    // the bus is quiet for loads and after reset.
    assign mem.mem_wmask = store_q ? wmask : 4'b0000;

    // ---------------- load alignment / extension ----------------
    assign rdata_shift = mem.mem_rdata >> {alu_q[1:0], 3'b000};
    assign rdata_half  = alu_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        load_ext = mem.mem_rdata;
        unique case (op_q)
            3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b100:  load_ext = {24'd0, rdata_shift[7:0]};
            3'b001:  load_ext = {{16{rdata_half[15]}}, rdata_half};
            3'b101:  load_ext = {16'd0, rdata_half};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    // ---------------- writeback bundle ----------------
    // Non-memory bundles go straight to DONE, so they are packed from the
    // exu inputs at acceptance; memory bundles are packed from the captured
    // fields when the response arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsu_data <= '0;
        end else if (accept && !is_mem_in) begin
            lsu_data <= {exu_alu_result, {WIDTH{1'b0}}, exu_rd_wen, exu_rd_addr,
                         exu_rd_input_sel, exu_csr_data};
        end else if (state == WAIT_RESP && mem.mem_resp_valid) begin
            lsu_data <= {alu_q, (load_q ? load_ext : {WIDTH{1'b0}}), rd_wen_q,
                         rd_addr_q, sel_q, csr_q};
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed + randomized self-checking bench for lsu_stage.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lsu_stage;

    logic         clk;
    logic         rst;
    logic         exu_valid;
    logic         exu_ready;
    logic [31:0]  exu_alu_result;
    logic [31:0]  exu_wdata;
    logic         exu_mem_ren;
    logic         exu_mem_wen;
    logic [2:0]   exu_mem_op;
    logic         exu_rd_wen;
    logic [4:0]   exu_rd_addr;
    logic [1:0]   exu_rd_input_sel;
    logic [31:0]  exu_csr_data;
    logic         lsu_valid;
    logic [103:0] lsu_data;

    int unsigned  checks;
    int unsigned  failures;
    logic [103:0] last_exp;

    lsu_stage_if #(.WIDTH(32)) mem_if ();

    lsu_stage #(.WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .exu_valid        (exu_valid),
        .exu_ready        (exu_ready),
        .exu_alu_result   (exu_alu_result),
        .exu_wdata        (exu_wdata),
        .exu_mem_ren      (exu_mem_ren),
        .exu_mem_wen      (exu_mem_wen),
        .exu_mem_op       (exu_mem_op),
        .exu_rd_wen       (exu_rd_wen),
        .exu_rd_addr      (exu_rd_addr),
        .exu_rd_input_sel (exu_rd_input_sel),
        .exu_csr_data     (exu_csr_data),
        .mem              (mem_if),
        .lsu_valid        (lsu_valid),
        .lsu_data         (lsu_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from funct3; anything that is not b/h/bu/hu is a word.
    function automatic int unsigned access_bytes(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd4) return 1;
        if (op == 3'd1 || op == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] op,
                                             input logic [31:0] rd);
        int unsigned n, off;
        logic [31:0] v;
        n   = access_bytes(op);
        off = ((addr % 4) / n) * n;
        v   = rd >> (8 * off);
        if (n < 4) begin
            v = v & ((32'd1 << (8 * n)) - 32'd1);
            if ((op == 3'd0 || op == 3'd1) && v >= (32'd1 << (8 * n - 1)))
                v = v | (32'hFFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] d,
                             output logic [3:0] mask, output logic [31:0] wd);
        int unsigned n, off;
        logic [31:0] dd;
        n    = access_bytes(op);
        off  = ((addr % 4) / n) * n;
        mask = 4'(((32'd1 << n) - 32'd1) << off);
        dd   = d;
        wd   = '0;
        for (int k = 0; k < 4; k++)
            wd = wd | (((dd >> (8 * (k % n))) & 32'hFF) << (8 * k));
    endtask

    task automatic scramble_exu();
        exu_alu_result   = $urandom;
        exu_wdata        = $urandom;
        exu_mem_ren      = 1'($urandom);
        exu_mem_wen      = 1'($urandom);
        exu_mem_op       = 3'($urandom);
        exu_rd_wen       = 1'($urandom);
        exu_rd_addr      = 5'($urandom);
        exu_rd_input_sel = 2'($urandom);
        exu_csr_data     = $urandom;
    endtask

    // Called on a falling edge with the DUT idle; returns on the falling edge
    // after the lsu_valid pulse, so the next call is accepted back-to-back.
    task automatic run_bundle(input logic [31:0] alu, input logic [31:0] wd,
                              input logic ren, input logic wen, input logic [2:0] op,
                              input logic rdw, input logic [4:0] rda, input logic [1:0] sel,
                              input logic [31:0] csr, input int unsigned stall,
                              input int unsigned dly, input logic [31:0] rdata);
        logic [31:0]  exp_ld;
        logic [103:0] exp;
        logic [3:0]   exp_mask;
        logic [31:0]  exp_wd;
        logic         is_store;
        is_store = wen && !ren;
        exp_ld   = ren ? ref_load(alu, op, rdata) : 32'd0;
        exp      = {alu, exp_ld, rdw, rda, sel, csr};
        ref_store(alu, op, wd, exp_mask, exp_wd);

        chk("exu_ready_idle", 104'(exu_ready), 104'(1));
        exu_valid        = 1'b1;
        exu_alu_result   = alu;
        exu_wdata        = wd;
        exu_mem_ren      = ren;
        exu_mem_wen      = wen;
        exu_mem_op       = op;
        exu_rd_wen       = rdw;
        exu_rd_addr      = rda;
        exu_rd_input_sel = sel;
        exu_csr_data     = csr;
        @(negedge clk);
        exu_valid = 1'b0;
        scramble_exu();
        chk("exu_ready_busy", 104'(exu_ready), 104'(0));

        if (ren || wen) begin
            for (int unsigned i = 0; i <= stall; i++) begin
                chk("req_valid", 104'(mem_if.mem_req_valid), 104'(1));
                chk("mem_addr", 104'(mem_if.mem_addr), 104'({alu[31:2], 2'b00}));
                chk("mem_wen", 104'(mem_if.mem_wen), 104'(is_store));
                if (is_store) begin
                    chk("mem_wdata", 104'(mem_if.mem_wdata), 104'(exp_wd));
                    chk("mem_wmask", 104'(mem_if.mem_wmask), 104'(exp_mask));
                end else begin
                    chk("mem_wmask_load", 104'(mem_if.mem_wmask), 104'(0));
                end
                chk("lsu_valid_req", 104'(lsu_valid), 104'(0));
                mem_if.mem_req_ready = (i == stall);
                @(negedge clk);
            end
            mem_if.mem_req_ready = 1'b0;
            chk("req_drop", 104'(mem_if.mem_req_valid), 104'(0));
            for (int unsigned i = 0; i < dly; i++) begin
                chk("lsu_valid_wait", 104'(lsu_valid), 104'(0));
                @(negedge clk);
                chk("req_wait", 104'(mem_if.mem_req_valid), 104'(0));
            end
            mem_if.mem_resp_valid = 1'b1;
            mem_if.mem_rdata      = rdata;
            @(negedge clk);
            mem_if.mem_resp_valid = 1'b0;
            mem_if.mem_rdata      = $urandom;
        end else begin
            chk("no_req", 104'(mem_if.mem_req_valid), 104'(0));
        end

        chk("lsu_valid_done", 104'(lsu_valid), 104'(1));
        chk("lsu_data", lsu_data, exp);
        @(negedge clk);
        chk("lsu_valid_pulse", 104'(lsu_valid), 104'(0));
        chk("lsu_data_hold", lsu_data, exp);
        chk("exu_ready_after", 104'(exu_ready), 104'(1));
        last_exp = exp;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_exp  = '0;
        rst       = 1'b0;
        exu_valid = 1'b0;
        scramble_exu();
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_rdata      = '0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst_lsu_valid", 104'(lsu_valid), 104'(0));
        chk("rst_req_valid", 104'(mem_if.mem_req_valid), 104'(0));
        chk("rst_lsu_data", lsu_data, 104'(0));
        chk("rst_mem_bus", 104'({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wen, mem_if.mem_wmask}),
            104'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("rel_exu_ready", 104'(exu_ready), 104'(1));
        chk("rel_lsu_valid", 104'(lsu_valid), 104'(0));

        // ALU op
        run_bundle(32'h1234, 32'h0, 1'b0, 1'b0, 3'd2, 1'b1, 5'd5, 2'b00, 32'hA5, 0, 0, 32'h0);
        // lb / lbu, best-case latency
        run_bundle(32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 5'd7, 2'b01, 32'h0, 0, 0, 32'h80FF_0000);
        run_bundle(32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'd4, 1'b1, 5'd7, 2'b01, 32'h0, 0, 0, 32'h80FF_0000);
        // sh with a 3-cycle request stall
        run_bundle(32'h102, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'd1, 1'b0, 5'd0, 2'b00, 32'h0, 3, 1, 32'h0);
        // lhu at 0x6
        run_bundle(32'h6, 32'h0, 1'b1, 1'b0, 3'd5, 1'b1, 5'd9, 2'b01, 32'h0, 0, 2, 32'h9ABC_1234);
        // ren+wen together acts as a load; undefined op acts as word
        run_bundle(32'h43, 32'h1111_2222, 1'b1, 1'b1, 3'd7, 1'b1, 5'd3, 2'b01, 32'h5, 1, 0, 32'hCAFE_F00D);

        // Stray response while idle
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_rdata      = 32'h7777_7777;
        @(negedge clk);
        mem_if.mem_resp_valid = 1'b0;
        chk("stray_lsu_valid", 104'(lsu_valid), 104'(0));
        chk("stray_exu_ready", 104'(exu_ready), 104'(1));
        chk("stray_lsu_data", lsu_data, last_exp);

        // Reset while in REQ: request drops asynchronously
        exu_valid = 1'b1; exu_mem_ren = 1'b1; exu_mem_wen = 1'b0; exu_alu_result = 32'h40;
        @(negedge clk);
        exu_valid = 1'b0;
        chk("rreq_req_valid", 104'(mem_if.mem_req_valid), 104'(1));
        rst = 1'b0;
        #1;
        chk("rreq_req_drop", 104'(mem_if.mem_req_valid), 104'(0));
        chk("rreq_exu_ready", 104'(exu_ready), 104'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset while in WAIT_RESP, then a late response
        exu_valid = 1'b1; exu_mem_ren = 1'b1; exu_mem_wen = 1'b0; exu_alu_result = 32'h80;
        @(negedge clk);
        exu_valid = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_if.mem_req_ready = 1'b0;
        chk("rwait_exu_ready", 104'(exu_ready), 104'(0));
        rst = 1'b0;
        #1;
        chk("rwait_exu_ready_rst", 104'(exu_ready), 104'(1));
        chk("rwait_lsu_valid_rst", 104'(lsu_valid), 104'(0));
        @(negedge clk);
        rst = 1'b1;
        mem_if.mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_if.mem_resp_valid = 1'b0;
        chk("rwait_late_lsu_valid", 104'(lsu_valid), 104'(0));
        chk("rwait_late_exu_ready", 104'(exu_ready), 104'(1));
        chk("rwait_late_req", 104'(mem_if.mem_req_valid), 104'(0));

        // Randomized bundles, back-to-back
        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            run_bundle($urandom, $urandom, (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                       3'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Multi-cycle load/store stage sitting directly upstream of the writeback stage.
- Accepts one instruction bundle from the execute stage and performs at most one data-memory access over a simple valid/ready request plus valid response bus.
- Aligns and sign/zero-extends load data.
- Emits a one-cycle lsu_valid pulse with the packed 104-bit lsu_data bundle that the writeback stage consumes.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported (bundle layout fixed).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- exu_valid  in  1  execute bundle valid
- exu_ready  out  1  stage can accept a bundle (state IDLE)
- exu_alu_result  in  32  ALU result; also the memory byte address
- exu_wdata  in  32  store data (rs2)
- exu_mem_ren  in  1  load
- exu_mem_wen  in  1  store
- exu_mem_op  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- exu_rd_wen  in  1  passthrough
- exu_rd_addr  in  5  passthrough
- exu_rd_input_sel  in  2  passthrough (01 = load data, 10 = csr, else alu)
- exu_csr_data  in  32  passthrough
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wen  out  1  1 = write
- mem_wdata  out  32  store data shifted to byte lane
- mem_wmask  out  4  byte enables
- mem_resp_valid  in  1  response/ack valid
- mem_rdata  in  32  read word
- lsu_valid  out  1  one-cycle pulse: lsu_data valid
- lsu_data  out  104  [103:72] alu_result, [71:40] load data, [39] rd_wen, [38:34] rd_addr, [33:32] rd_input_sel, [31:0] csr_data

Behaviour:
- Reset (rst=0, async): state IDLE; mem_req_valid=0, lsu_valid=0, lsu_data=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0. exu_ready=1 when rst=1 and state IDLE.
- States: IDLE, REQ, WAIT_RESP, DONE.
- exu_ready = (state==IDLE), combinational from state only.
- Acceptance happens when exu_valid & exu_ready at a clock edge. All bundle fields are registered; inputs are ignored afterwards.
- Transitions after acceptance:
  - exu_mem_ren|exu_mem_wen -> REQ.
  - Otherwise -> DONE (load data field = 0).
- If ren and wen are both set, the access is treated as a load (mem_wen=0).
- REQ: mem_req_valid=1. mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until mem_req_ready=1, then -> WAIT_RESP. mem_req_valid drops the cycle after the handshake.
- WAIT_RESP: the first mem_resp_valid=1 captures mem_rdata (loads only) and moves to DONE. mem_resp_valid in any other state is ignored. Stores also wait for the response (write ack).
- DONE: lsu_valid=1 for exactly one cycle, then -> IDLE. lsu_data is registered and holds its value until the next DONE. There is no downstream backpressure.
- Latency: a non-memory bundle gives lsu_valid 1 cycle after acceptance. A memory bundle gives lsu_valid 1 cycle after the response edge. Best case for a load is 3 cycles (ready in the first REQ cycle, response the next cycle).
- Lane select uses the registered addr[1:0]:
  - byte: lane addr[1:0]; wmask = 4'b0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: lane addr[1]; wmask = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}; addr[0] is ignored.
  - word: wmask = 1111; addr[1:0] is ignored.
  - Misalignment is not trapped.
- Load extension: b/h sign-extend, bu/hu zero-extend, w passthrough. Undefined mem_op values are treated as w.
- Back-to-back: the next bundle can be accepted in the cycle after DONE (IDLE). Maximum throughput is one instruction per 2 cycles for non-memory bundles.
- Reset mid-operation: any state returns to IDLE immediately. mem_req_valid and lsu_valid drop asynchronously. A late mem_resp_valid after reset is ignored.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles -> exu_ready=1 after release; lsu_valid=0, mem_req_valid=0, lsu_data=0.
- ALU op: alu_result=0x1234, rd_wen=1, rd_addr=5, sel=00, csr=0xA5 -> lsu_valid pulses 1 cycle after accept. lsu_data = {0x1234, 0, 1, 5, 00, 0xA5}. No mem_req_valid.
- lb sign-extend: addr=0x80000003, mem_rdata=0x80FF0000 -> mem_addr=0x80000000, mem_wen=0. Load field = 0xFFFFFF80. Same with lbu -> 0x00000080.
- sh with stall: addr=0x102, wdata=0xDEADBEEF, mem_req_ready low 3 cycles -> mem_req_valid held 4 cycles with mem_addr=0x100, wdata=0xBEEFBEEF, wmask=1100. lsu_valid follows the ack by 1 cycle.
- lhu at addr 0x6, mem_rdata=0x9ABC1234 -> load field = 0x00009ABC. Stray mem_resp_valid while IDLE -> no effect.
- Reset in WAIT_RESP: assert rst=0 for 1 cycle, then send mem_resp_valid -> no lsu_valid, state IDLE, exu_ready=1.
